// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: 16x32 register file, RAW scoreboard, operand muxing and
// a registered valid/ready bundle feeding the ALU/barrel-shifter, plus NZCV flags.
module alu_operand_stage #(
    parameter int unsigned NREGS     = 16,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        rn_en,
    input  logic [3:0]  rn_addr,
    input  logic [3:0]  rm_addr,
    input  logic [3:0]  rs_addr,
    input  logic        imm_en,
    input  logic [31:0] imm32,
    input  logic        shift_reg_en,
    input  logic [4:0]  shift_imm,
    input  logic [2:0]  shift_op_in,
    input  logic [3:0]  alu_op_in,
    input  logic        s_in,
    input  logic        rd_we_in,
    input  logic [3:0]  rd_addr_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] Shift_Data,
    output logic [7:0]  Shift_Num,
    output logic [2:0]  SHIFT_OP,
    output logic [3:0]  ALU_OP,
    output logic        S,
    output logic        rd_we_out,
    output logic [3:0]  rd_addr_out,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        flags_we,
    input  logic [3:0]  nzcv_in,
    output logic [3:0]  nzcv,
    output logic        carry_flag
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 8;

    logic [DW-1:0]    regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic [NREGS-1:0] pending_eff;
    logic [NREGS-1:0] wb_onehot;
    logic [DW-1:0]    rn_val;
    logic [DW-1:0]    rm_val;
    logic [SW-1:0]    rs_lo;
    logic             haz;
    logic             fire;

    // Register reads with same-cycle writeback forwarding; hazards ignore bits
    // that the current writeback is about to clear.
    always_comb begin
        wb_onehot = '0;
        if (wb_en) begin
            wb_onehot[wb_addr] = 1'b1;
        end
        pending_eff = pending & ~wb_onehot;

        rn_val = (wb_en && (wb_addr == rn_addr)) ? wb_data : regs[rn_addr];
        rm_val = (wb_en && (wb_addr == rm_addr)) ? wb_data : regs[rm_addr];
        rs_lo  = (wb_en && (wb_addr == rs_addr)) ? wb_data[SW-1:0] : regs[rs_addr][SW-1:0];

        haz = (rn_en & pending_eff[rn_addr])
            | (!imm_en & pending_eff[rm_addr])
            | (shift_reg_en & pending_eff[rs_addr]);

        in_ready = !haz && (!out_valid || out_ready);
        fire     = in_valid && in_ready;

        // Clear first so a same-index set from a newer writer wins.
        pending_next = pending & ~wb_onehot;
        if (fire && rd_we_in) begin
            pending_next[rd_addr_in] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wb_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    // Output bundle: loads on accept, holds under back-pressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            A           <= '0;
            Shift_Data  <= '0;
            Shift_Num   <= '0;
            SHIFT_OP    <= '0;
            ALU_OP      <= '0;
            S           <= 1'b0;
            rd_we_out   <= 1'b0;
            rd_addr_out <= '0;
        end else if (fire) begin
            out_valid   <= 1'b1;
            A           <= rn_en ? rn_val : '0;
            Shift_Data  <= imm_en ? imm32 : rm_val;
            Shift_Num   <= shift_reg_en ? rs_lo : SW'({3'b000, shift_imm});
            SHIFT_OP    <= shift_op_in;
            ALU_OP      <= alu_op_in;
            S           <= s_in;
            rd_we_out   <= rd_we_in;
            rd_addr_out <= rd_addr_in;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nzcv <= '0;
        end else if (flags_we) begin
            nzcv <= nzcv_in;
        end
    end

    assign carry_flag = nzcv[1];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: scoreboard of accepted bundles
// plus per-scenario inline checks of handshake, hazards and flags.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic        rn_en;
    logic [3:0]  rn_addr, rm_addr, rs_addr;
    logic        imm_en;
    logic [31:0] imm32;
    logic        shift_reg_en;
    logic [4:0]  shift_imm;
    logic [2:0]  shift_op_in;
    logic [3:0]  alu_op_in;
    logic        s_in, rd_we_in;
    logic [3:0]  rd_addr_in;
    logic        out_valid, out_ready;
    logic [31:0] A, Shift_Data;
    logic [7:0]  Shift_Num;
    logic [2:0]  SHIFT_OP;
    logic [3:0]  ALU_OP;
    logic        S, rd_we_out;
    logic [3:0]  rd_addr_out;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flags_we;
    logic [3:0]  nzcv_in, nzcv;
    logic        carry_flag;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] sd;
        logic [7:0]  sn;
        logic [2:0]  sop;
        logic [3:0]  aop;
        logic        s;
        logic        rdwe;
        logic [3:0]  rda;
    } bundle_t;

    bundle_t     exp_q[$];
    logic [31:0] model_regs [16];
    int          n_cmp = 0;
    int          n_err = 0;

    alu_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rn_en(rn_en), .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
        .imm_en(imm_en), .imm32(imm32), .shift_reg_en(shift_reg_en), .shift_imm(shift_imm),
        .shift_op_in(shift_op_in), .alu_op_in(alu_op_in), .s_in(s_in),
        .rd_we_in(rd_we_in), .rd_addr_in(rd_addr_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .Shift_Data(Shift_Data), .Shift_Num(Shift_Num), .SHIFT_OP(SHIFT_OP),
        .ALU_OP(ALU_OP), .S(S), .rd_we_out(rd_we_out), .rd_addr_out(rd_addr_out),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flags_we(flags_we), .nzcv_in(nzcv_in), .nzcv(nzcv), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    // Reference register file
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) model_regs[i] <= 32'h0;
        end else if (wb_en) begin
            model_regs[wb_addr] <= wb_data;
        end
    end

    function automatic logic [31:0] model_rd(input logic [3:0] addr);
        return (wb_en && wb_addr == addr) ? wb_data : model_regs[addr];
    endfunction

    // Scoreboard: pop on consume, push on accept, both decided at the falling edge
    always @(negedge clk) begin
        bundle_t exp_b, obs_b;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                obs_b = '{A, Shift_Data, Shift_Num, SHIFT_OP, ALU_OP, S, rd_we_out, rd_addr_out};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bundle_unexpected: got %h, expected nothing queued", obs_b);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (obs_b !== exp_b) begin
                        n_err++;
                        $display("FAIL bundle: got %h, expected %h", obs_b, exp_b);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_b.a    = rn_en ? model_rd(rn_addr) : 32'h0;
                exp_b.sd   = imm_en ? imm32 : model_rd(rm_addr);
                exp_b.sn   = shift_reg_en ? model_rd(rs_addr) & 32'hFF : {3'b000, shift_imm};
                exp_b.sop  = shift_op_in;
                exp_b.aop  = alu_op_in;
                exp_b.s    = s_in;
                exp_b.rdwe = rd_we_in;
                exp_b.rda  = rd_addr_in;
                exp_q.push_back(exp_b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; rn_en = 0; rn_addr = 0; rm_addr = 0; rs_addr = 0;
        imm_en = 0; imm32 = 0; shift_reg_en = 0; shift_imm = 0;
        shift_op_in = 0; alu_op_in = 0; s_in = 0; rd_we_in = 0; rd_addr_in = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; flags_we = 0; nzcv_in = 0;
    endtask

    task automatic drain();
        in_valid = 0; wb_en = 0; flags_we = 0; out_ready = 1;
        tick();
        tick();
    endtask

    task automatic set_instr(input logic rne, input logic [3:0] rn, input logic [3:0] rm,
                             input logic [3:0] rs, input logic ie, input logic [31:0] imm,
                             input logic sre, input logic [4:0] simm, input logic [2:0] sop,
                             input logic [3:0] aop, input logic s, input logic rdwe,
                             input logic [3:0] rd);
        in_valid = 1; rn_en = rne; rn_addr = rn; rm_addr = rm; rs_addr = rs;
        imm_en = ie; imm32 = imm; shift_reg_en = sre; shift_imm = simm;
        shift_op_in = sop; alu_op_in = aop; s_in = s; rd_we_in = rdwe; rd_addr_in = rd;
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
        wb_en = 1; wb_addr = addr; wb_data = data;
        tick();
        wb_en = 0;
    endtask

    task automatic test_reset();
        idle();
        out_ready = 1;
        rst = 1;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || A !== 32'h0 || Shift_Num !== 8'h0 || ALU_OP !== 4'h0) begin
            n_err++;
            $display("FAIL reset_outputs: out_valid=%b A=%h sn=%h aop=%h, expected 0s", out_valid, A, Shift_Num, ALU_OP);
        end
        n_cmp++;
        if (nzcv !== 4'h0 || carry_flag !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: nzcv=%b carry=%b, expected 0000/0", nzcv, carry_flag);
        end
        rst = 0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        write_reg(4'd3, 32'h12345678);
        set_instr(1, 4'd3, 4'd4, 4'd0, 0, 32'h0, 0, 5'd5, 3'd2, 4'h4, 1, 0, 4'd0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ready: in_ready=%b, expected 1", in_ready);
        end
        tick();
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 1'b1 || A !== 32'h12345678 || Shift_Data !== 32'h0 || Shift_Num !== 8'h05) begin
            n_err++;
            $display("FAIL basic_bundle: ov=%b A=%h sd=%h sn=%h, expected 1/12345678/0/05", out_valid, A, Shift_Data, Shift_Num);
        end
        drain();
    endtask

    task automatic test_hazard();
        set_instr(1, 4'd3, 4'd0, 4'd0, 1, 32'h1, 0, 5'd0, 3'd0, 4'h2, 0, 1, 4'd2);
        tick();
        set_instr(1, 4'd2, 4'd0, 4'd0, 1, 32'h2, 0, 5'd1, 3'd1, 4'h3, 0, 0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hazard_stall%0d: in_ready=%b, expected 0", i, in_ready);
            end
            tick();
        end
        wb_en = 1; wb_addr = 4'd2; wb_data = 32'hA5;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hazard_bypass_ready: in_ready=%b, expected 1", in_ready);
        end
        tick();
        in_valid = 0; wb_en = 0;
        n_cmp++;
        if (out_valid !== 1'b1 || A !== 32'hA5) begin
            n_err++;
            $display("FAIL hazard_bypass_a: ov=%b A=%h, expected 1/000000a5", out_valid, A);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 0;
        set_instr(1, 4'd3, 4'd0, 4'd0, 1, 32'h11, 0, 5'd2, 3'd3, 4'h1, 0, 0, 4'd0);
        tick();
        set_instr(0, 4'd0, 4'd0, 4'd0, 1, 32'hDEAD, 0, 5'd7, 3'd4, 4'h7, 1, 0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || A !== 32'h12345678 || ALU_OP !== 4'h1) begin
                n_err++;
                $display("FAIL hold%0d: ready=%b ov=%b A=%h aop=%h, expected 0/1/12345678/1", i, in_ready, out_valid, A, ALU_OP);
            end
            tick();
        end
        out_ready = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: in_ready=%b, expected 1", in_ready);
        end
        tick();
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 1'b1 || ALU_OP !== 4'h7 || Shift_Data !== 32'hDEAD || A !== 32'h0) begin
            n_err++;
            $display("FAIL release_bundle: ov=%b aop=%h sd=%h A=%h, expected 1/7/0000dead/0", out_valid, ALU_OP, Shift_Data, A);
        end
        drain();
    endtask

    task automatic test_shift_imm();
        write_reg(4'd7, 32'h00000120);
        set_instr(0, 4'd0, 4'd0, 4'd0, 1, 32'h0, 0, 5'd0, 3'd0, 4'h0, 0, 1, 4'd9);
        tick();
        set_instr(0, 4'd0, 4'd9, 4'd7, 1, 32'hFF, 1, 5'd3, 3'd1, 4'h5, 0, 0, 4'd0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL imm_ignores_pending: in_ready=%b, expected 1", in_ready);
        end
        tick();
        in_valid = 0;
        n_cmp++;
        if (Shift_Num !== 8'h20 || Shift_Data !== 32'hFF) begin
            n_err++;
            $display("FAIL shift_reg_imm: sn=%h sd=%h, expected 20/000000ff", Shift_Num, Shift_Data);
        end
        set_instr(0, 4'd0, 4'd9, 4'd0, 0, 32'h0, 0, 5'd1, 3'd0, 4'h6, 0, 0, 4'd0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rm_stall: in_ready=%b, expected 0", in_ready);
        end
        tick();
        wb_en = 1; wb_addr = 4'd9; wb_data = 32'hCAFE0009;
        tick();
        in_valid = 0; wb_en = 0;
        n_cmp++;
        if (out_valid !== 1'b1 || Shift_Data !== 32'hCAFE0009) begin
            n_err++;
            $display("FAIL rm_bypass: ov=%b sd=%h, expected 1/cafe0009", out_valid, Shift_Data);
        end
        drain();
    endtask

    task automatic test_flags();
        flags_we = 1; nzcv_in = 4'b0010;
        #1;
        n_cmp++;
        if (carry_flag !== 1'b0) begin
            n_err++;
            $display("FAIL flags_no_bypass: carry=%b, expected 0", carry_flag);
        end
        tick();
        flags_we = 0; nzcv_in = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (nzcv !== 4'b0010 || carry_flag !== 1'b1) begin
                n_err++;
                $display("FAIL flags%0d: nzcv=%b carry=%b, expected 0010/1", i, nzcv, carry_flag);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 0;
        set_instr(1, 4'd3, 4'd0, 4'd0, 1, 32'h0, 0, 5'd0, 3'd0, 4'h8, 0, 1, 4'd5);
        tick();
        set_instr(1, 4'd5, 4'd0, 4'd0, 1, 32'h0, 0, 5'd0, 3'd0, 4'h9, 0, 0, 4'd0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_stall: ready=%b ov=%b, expected 0/1", in_ready, out_valid);
        end
        #1;
        in_valid = 0;
        rst = 1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || A !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: ov=%b ready=%b A=%h, expected 0/1/0", out_valid, in_ready, A);
        end
        tick();
        rst = 0;
        out_ready = 1;
        in_valid = 1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_ready: in_ready=%b, expected 1", in_ready);
        end
        tick();
        in_valid = 0;
        n_cmp++;
        if (out_valid !== 1'b1 || A !== 32'h0 || ALU_OP !== 4'h9) begin
            n_err++;
            $display("FAIL post_reset_bundle: ov=%b A=%h aop=%h, expected 1/0/9", out_valid, A, ALU_OP);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hazard();
        test_back_to_back();
        test_shift_imm();
        test_flags();
        test_reset_mid_stall();
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d bundles left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
